// File: rtl/fetch_next_pc_predictor.sv
`default_nettype none
// ============================================================================
// fetch_next_pc_predictor : fetch PC, direct-mapped BTB and execute redirect
// Revision: 1.0
// ============================================================================
module fetch_next_pc_predictor #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0060,
  parameter int          BTB_ENTRIES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_stall,
  output logic [31:0] pc_out,
  input  logic        bht_taken,
  output logic        pred_taken,
  input  logic        br_info_avail,
  input  logic        ex_taken,
  input  logic        ex_uncond,
  input  logic [31:0] ex_target,
  output logic        flush,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int c_IDX_W = $clog2(BTB_ENTRIES);
  localparam int c_TAG_W = 30 - c_IDX_W;

  logic [31:0]            r_pc;

  logic [BTB_ENTRIES-1:0] r_btb_valid;
  logic [BTB_ENTRIES-1:0] r_btb_uncond;
  logic [c_TAG_W-1:0]     r_btb_tag    [BTB_ENTRIES];
  logic [31:0]            r_btb_target [BTB_ENTRIES];

  logic                   r_dec_valid;
  logic [31:0]            r_dec_pc;
  logic                   r_dec_pred_taken;
  logic [31:0]            r_dec_pred_target;
  logic                   r_ex_valid;
  logic [31:0]            r_ex_pc;
  logic                   r_ex_pred_taken;
  logic [31:0]            r_ex_pred_target;

  logic [31:0]            r_br_count;
  logic [31:0]            r_mispred_count;

  logic [c_IDX_W-1:0]     w_idx;
  logic [c_TAG_W-1:0]     w_tag;
  logic [c_IDX_W-1:0]     w_ex_idx;
  logic [c_TAG_W-1:0]     w_ex_tag;
  logic                   w_hit;
  logic                   w_pred_taken;
  logic [31:0]            w_pred_next;
  logic                   w_res;
  logic                   w_redirect;
  logic [31:0]            w_actual_next;
  logic                   w_btb_wr;

  // Fetch-side lookup: purely combinational from the current PC.
  assign w_idx        = r_pc[c_IDX_W+1:2];
  assign w_tag        = r_pc[31:c_IDX_W+2];
  assign w_hit        = r_btb_valid[w_idx] && (r_btb_tag[w_idx] == w_tag);
  assign w_pred_taken = w_hit && (r_btb_uncond[w_idx] || bht_taken);
  assign w_pred_next  = w_pred_taken ? r_btb_target[w_idx] : r_pc + 32'd4;

  // Execute-side resolution against the prediction carried down the pipe.
  assign w_ex_idx      = r_ex_pc[c_IDX_W+1:2];
  assign w_ex_tag      = r_ex_pc[31:c_IDX_W+2];
  assign w_res         = br_info_avail && r_ex_valid && !mem_stall;
  assign w_actual_next = ex_taken ? ex_target : r_ex_pc + 32'd4;
  assign w_redirect    = w_res && ((ex_taken != r_ex_pred_taken) ||
                                   (ex_taken && (ex_target != r_ex_pred_target)));
  assign w_btb_wr      = w_res && ex_taken;

  assign pc_out        = r_pc;
  assign pred_taken    = w_pred_taken;
  assign flush         = w_redirect;
  assign br_count      = r_br_count;
  assign mispred_count = r_mispred_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (!mem_stall) begin
      r_pc <= w_redirect ? w_actual_next : w_pred_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_valid       <= 1'b0;
      r_dec_pc          <= '0;
      r_dec_pred_taken  <= 1'b0;
      r_dec_pred_target <= '0;
      r_ex_valid        <= 1'b0;
      r_ex_pc           <= '0;
      r_ex_pred_taken   <= 1'b0;
      r_ex_pred_target  <= '0;
    end else if (!mem_stall) begin
      if (w_redirect) begin
        r_dec_valid <= 1'b0;
        r_ex_valid  <= 1'b0;
      end else begin
        r_dec_valid       <= 1'b1;
        r_dec_pc          <= r_pc;
        r_dec_pred_taken  <= w_pred_taken;
        r_dec_pred_target <= w_pred_next;
        r_ex_valid        <= r_dec_valid;
        r_ex_pc           <= r_dec_pc;
        r_ex_pred_taken   <= r_dec_pred_taken;
        r_ex_pred_target  <= r_dec_pred_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else begin
      if (w_res) begin
        r_br_count <= r_br_count + 32'd1;
      end
      if (w_redirect) begin
        r_mispred_count <= r_mispred_count + 32'd1;
      end
    end
  end

  // Only the valid/uncond bits need clearing; tag and target are qualified by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btb_valid  <= '0;
      r_btb_uncond <= '0;
    end else if (w_btb_wr) begin
      r_btb_valid[w_ex_idx]  <= 1'b1;
      r_btb_uncond[w_ex_idx] <= ex_uncond;
    end
  end

  always_ff @(posedge clk) begin
    if (w_btb_wr) begin
      r_btb_tag[w_ex_idx]    <= w_ex_tag;
      r_btb_target[w_ex_idx] <= ex_target;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_next_pc_predictor.sv
`default_nettype none
// Bench for fetch_next_pc_predictor: directed vector table, reset sequences
// and randomized traffic against a queue-based reference model.
module tb_fetch_next_pc_predictor;

  localparam int unsigned c_ENTRIES  = 32;
  localparam int unsigned c_SPAN     = 4 * c_ENTRIES;
  localparam logic [31:0] c_RESET_PC = 32'h0000_0060;

  logic        clk           = 1'b0;
  logic        rst_n         = 1'b1;
  logic        mem_stall     = 1'b0;
  logic        bht_taken     = 1'b0;
  logic        br_info_avail = 1'b0;
  logic        ex_taken      = 1'b0;
  logic        ex_uncond     = 1'b0;
  logic [31:0] ex_target     = '0;
  logic [31:0] pc_out;
  logic        pred_taken;
  logic        flush;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  fetch_next_pc_predictor #(
    .RESET_PC    (c_RESET_PC),
    .BTB_ENTRIES (c_ENTRIES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_stall     (mem_stall),
    .pc_out        (pc_out),
    .bht_taken     (bht_taken),
    .pred_taken    (pred_taken),
    .br_info_avail (br_info_avail),
    .ex_taken      (ex_taken),
    .ex_uncond     (ex_uncond),
    .ex_target     (ex_target),
    .flush         (flush),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] pr,
                         input logic [31:0] fl, input logic [31:0] br, input logic [31:0] mi);
    chk({tag, " pc_out"}, pc_out, pc);
    chk({tag, " pred_taken"}, 32'(pred_taken), pr);
    chk({tag, " flush"}, 32'(flush), fl);
    chk({tag, " br_count"}, br_count, br);
    chk({tag, " mispred_count"}, mispred_count, mi);
  endtask

  task automatic drive(input logic s, input logic b, input logic a, input logic t,
                       input logic u, input logic [31:0] tg);
    mem_stall     = s;
    bht_taken     = b;
    br_info_avail = a;
    ex_taken      = t;
    ex_uncond     = u;
    ex_target     = tg;
  endtask

  // Directed vector: inputs for one cycle and the outputs expected before its edge.
  typedef struct {
    int unsigned stall, bht, bia, ext, exu, tgt;
    int unsigned pc, pred, fl, br, mis;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(input int unsigned s, b, a, t, u, tg, p, pr, f, br, mi);
    vec_t r;
    r.stall = s; r.bht = b; r.bia = a; r.ext = t; r.exu = u; r.tgt = tg;
    r.pc = p; r.pred = pr; r.fl = f; r.br = br; r.mis = mi;
    return r;
  endfunction

  // Reference model: BTB keyed by full branch PC, in-flight fetches in a queue
  // (element 0 = decode, element 1 = execute).
  typedef struct { logic [31:0] pc; logic pt; logic [31:0] ptgt; } rec_t;
  logic [31:0] m_pc, m_br, m_mis;
  logic        m_bv   [c_ENTRIES];
  logic [31:0] m_bpc  [c_ENTRIES];
  logic [31:0] m_btgt [c_ENTRIES];
  logic        m_bu   [c_ENTRIES];
  rec_t        m_q[$];
  logic [31:0] pool [8];

  function automatic void m_reset();
    m_pc = c_RESET_PC; m_br = '0; m_mis = '0;
    m_q.delete();
    for (int i = 0; i < int'(c_ENTRIES); i++) m_bv[i] = 1'b0;
  endfunction

  initial begin
    logic s, b, a, t, u, pt, hit, res, redir;
    logic [31:0] tg, ptgt, actual;
    int slot, wslot;

    pool = '{32'h60, 32'h64, 32'h80, 32'h200, 32'h1064, 32'h240, 32'h300, 32'hFFFF_FFFC};

    // Asynchronous reset dropped mid-cycle.
    #2 rst_n = 1'b0;
    #1 chk_all("reset", 32'h60, 0, 0, 0, 0);
    #15 rst_n = 1'b1;

    //          stall bht bia ext exu tgt        pc        pred fl br mis
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h60,   0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h64,   0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h68,   0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0,        'h6C,   0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0,        'h6C,   0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 0, 'h200,    'h6C,   0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h200,  0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h204,  0, 0, 1, 1));
    tbl.push_back(v(0, 0, 1, 1, 0, 'h64,     'h208,  0, 1, 1, 1));
    tbl.push_back(v(0, 1, 0, 0, 0, 0,        'h64,   1, 0, 2, 2));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h200,  0, 0, 2, 2));
    tbl.push_back(v(0, 0, 1, 1, 0, 'h200,    'h204,  0, 0, 2, 2));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h208,  0, 0, 3, 2));
    tbl.push_back(v(0, 0, 1, 1, 0, 'h64,     'h20C,  0, 1, 3, 2));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h64,   0, 0, 4, 3));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h68,   0, 0, 4, 3));
    tbl.push_back(v(0, 0, 1, 1, 0, 'h200,    'h6C,   0, 1, 4, 3));
    tbl.push_back(v(0, 1, 0, 0, 0, 0,        'h200,  1, 0, 5, 4));
    tbl.push_back(v(0, 1, 0, 0, 0, 0,        'h64,   1, 0, 5, 4));
    tbl.push_back(v(0, 0, 1, 1, 0, 'h64,     'h200,  0, 0, 5, 4));
    tbl.push_back(v(0, 0, 1, 0, 0, 0,        'h204,  0, 1, 6, 4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h68,   0, 0, 7, 5));
    tbl.push_back(v(0, 1, 0, 0, 0, 0,        'h6C,   0, 0, 7, 5));
    tbl.push_back(v(0, 1, 0, 0, 0, 0,        'h70,   0, 0, 7, 5));
    tbl.push_back(v(0, 1, 0, 0, 0, 0,        'h74,   0, 0, 7, 5));
    tbl.push_back(v(0, 1, 0, 0, 0, 0,        'h78,   0, 0, 7, 5));
    tbl.push_back(v(0, 1, 0, 0, 0, 0,        'h7C,   0, 0, 7, 5));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h80,   0, 0, 7, 5));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h84,   0, 0, 7, 5));
    tbl.push_back(v(0, 0, 1, 1, 1, 'h240,    'h88,   0, 1, 7, 5));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h240,  0, 0, 8, 6));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h244,  0, 0, 8, 6));
    tbl.push_back(v(0, 0, 1, 1, 0, 'h80,     'h248,  0, 1, 8, 6));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h80,   1, 0, 9, 7));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h240,  0, 0, 9, 7));
    tbl.push_back(v(0, 0, 1, 1, 1, 'h300,    'h244,  0, 1, 9, 7));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h300,  0, 0, 10, 8));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h304,  0, 0, 10, 8));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h308,  0, 0, 10, 8));
    tbl.push_back(v(0, 0, 1, 1, 0, 'h80,     'h30C,  0, 1, 10, 8));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h80,   1, 0, 11, 9));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h300,  0, 0, 11, 9));
    tbl.push_back(v(0, 0, 1, 1, 1, 'h1064,   'h304,  0, 1, 11, 9));
    tbl.push_back(v(0, 1, 0, 0, 0, 0,        'h1064, 0, 0, 12, 10));
    tbl.push_back(v(0, 1, 0, 0, 0, 0,        'h1068, 0, 0, 12, 10));
    tbl.push_back(v(1, 0, 1, 1, 0, 'h500,    'h106C, 0, 0, 12, 10));
    tbl.push_back(v(1, 0, 1, 1, 0, 'h500,    'h106C, 0, 0, 12, 10));
    tbl.push_back(v(1, 0, 1, 1, 0, 'h500,    'h106C, 0, 0, 12, 10));
    tbl.push_back(v(0, 0, 1, 1, 0, 'h500,    'h106C, 0, 1, 12, 10));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h500,  0, 0, 13, 11));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,        'h504,  0, 0, 13, 11));

    foreach (tbl[i]) begin
      drive(tbl[i].stall != 0, tbl[i].bht != 0, tbl[i].bia != 0,
            tbl[i].ext != 0, tbl[i].exu != 0, tbl[i].tgt);
      #3 chk_all($sformatf("row%0d", i), tbl[i].pc, tbl[i].pred, tbl[i].fl,
                 tbl[i].br, tbl[i].mis);
      @(posedge clk); #1;
    end

    // Reset arriving while a redirect and BTB write are pending.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h700);
    #2 chk("prerst pc_out", pc_out, 32'h508);
    chk("prerst flush", 32'(flush), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_all("midrst", 32'h60, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 chk($sformatf("postrst%0d pc_out", i), pc_out, 32'h60 + 32'(4 * i));
      chk($sformatf("postrst%0d pred_taken", i), 32'(pred_taken), 32'd0);
      @(posedge clk); #1;
    end
    chk("postrst br_count", br_count, 32'd0);

    // Randomized traffic against the model.
    #2 rst_n = 1'b0;
    m_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    #2 rst_n = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      s  = ($urandom_range(0, 4) == 0);
      b  = ($urandom_range(0, 1) == 1);
      a  = ($urandom_range(0, 2) != 0);
      u  = ($urandom_range(0, 3) == 0);
      t  = u || ($urandom_range(0, 1) == 1);
      tg = pool[$urandom_range(0, 7)];
      if (m_q.size() == 2 && $urandom_range(0, 1) == 1) begin
        u  = 1'b0;
        t  = m_q[1].pt;
        tg = m_q[1].ptgt;
      end

      slot  = int'((m_pc >> 2) % c_ENTRIES);
      hit   = m_bv[slot] && ((m_bpc[slot] / c_SPAN) == (m_pc / c_SPAN));
      pt    = hit && (m_bu[slot] || b);
      ptgt  = pt ? m_btgt[slot] : m_pc + 32'd4;
      res   = a && (m_q.size() == 2) && !s;
      redir = 1'b0;
      actual = '0;
      if (res) begin
        actual = t ? tg : m_q[1].pc + 32'd4;
        redir  = (t != m_q[1].pt) || (t && (tg != m_q[1].ptgt));
      end

      drive(s, b, a, t, u, tg);
      #3 chk_all($sformatf("rnd%0d", cyc), m_pc, 32'(pt), 32'(redir), m_br, m_mis);

      if (!s) begin
        if (res) begin
          m_br = m_br + 32'd1;
          if (redir) m_mis = m_mis + 32'd1;
          if (t) begin
            wslot = int'((m_q[1].pc >> 2) % c_ENTRIES);
            m_bv[wslot]   = 1'b1;
            m_bpc[wslot]  = m_q[1].pc;
            m_btgt[wslot] = tg;
            m_bu[wslot]   = u;
          end
        end
        if (redir) begin
          m_q.delete();
          m_pc = actual;
        end else begin
          m_q.push_front('{pc: m_pc, pt: pt, ptgt: ptgt});
          if (m_q.size() > 2) void'(m_q.pop_back());
          m_pc = ptgt;
        end
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
